// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// ahb_pkg : shared AHB-Lite constants and master state encoding
// Rev 1.0
// ============================================================================
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_READ  = 2'b01;
  localparam logic [1:0] MODE_WRITE = 2'b10;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_ERR  = 2'd3
  } master_state_e;

endpackage
`default_nettype wire

// File: rtl/ahb_addr_gen.sv
`default_nettype none
// ============================================================================
// ahb_addr_gen : region base select plus element-index scaling by access size
// Rev 1.0
// ============================================================================
module ahb_addr_gen
  import ahb_pkg::*;
#(
  parameter logic [31:0] SRC_BASE = 32'h0000_0000,
  parameter logic [31:0] DST_BASE = 32'h0010_0000
) (
  input  logic [19:0] pix_num,
  input  logic [1:0]  size,
  input  logic        start_addr_sel,
  output logic [31:0] addr
);

  logic [31:0] base;
  logic [31:0] index;
  logic [31:0] offset;

  always_comb begin
    base  = start_addr_sel ? DST_BASE : SRC_BASE;
    index = {12'd0, pix_num};
    case (size)
      SIZE_BYTE: offset = index;
      SIZE_HALF: offset = index << 1;
      SIZE_WORD: offset = index << 2;
      default:   offset = index << 3;
    endcase
    // Sum wraps modulo 2^32 by construction.
    addr = base + offset;
  end

endmodule
`default_nettype wire

// File: rtl/ahb_master.sv
`default_nettype none
// ============================================================================
// ahb_master : single-transfer AHB-Lite master serving the helper request port
// Rev 1.0
// ============================================================================
module ahb_master
  import ahb_pkg::*;
#(
  parameter logic [31:0] SRC_BASE = 32'h0000_0000,
  parameter logic [31:0] DST_BASE = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [1:0]  mode,
  input  logic [19:0] pixNum,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        startAddr_sel,
  output logic [31:0] rdata,
  output logic        data_feedback,
  output logic        err,
  output logic        busy,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  master_state_e state;
  master_state_e next_state;

  logic [31:0] req_addr;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  size_q;
  logic        write_q;
  logic        accept;
  logic        done_ok;
  logic        done_err;

  ahb_addr_gen #(
    .SRC_BASE (SRC_BASE),
    .DST_BASE (DST_BASE)
  ) u_addr_gen (
    .pix_num        (pixNum),
    .size           (size),
    .start_addr_sel (startAddr_sel),
    .addr           (req_addr)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    done_ok    = 1'b0;
    done_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = (mode == MODE_READ) || (mode == MODE_WRITE);
        if (accept) next_state = ST_ADDR;
      end
      ST_ADDR: begin
        if (HREADY) next_state = ST_DATA;
      end
      ST_DATA: begin
        // An ERROR seen with HREADY already high is finished in one step.
        if (HRESP) begin
          done_err   = HREADY;
          next_state = HREADY ? ST_IDLE : ST_ERR;
        end else if (HREADY) begin
          done_ok    = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (HREADY) begin
          done_err   = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      size_q        <= 2'd0;
      write_q       <= 1'b0;
      rdata         <= 32'd0;
      data_feedback <= 1'b0;
      err           <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= wdata;
        size_q  <= size;
        write_q <= (mode == MODE_WRITE);
      end
      if (done_ok && !write_q) begin
        rdata <= HRDATA;
      end
      data_feedback <= done_ok;
      err           <= done_err;
    end
  end

  assign busy   = (state != ST_IDLE);
  assign HTRANS = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = addr_q;
  assign HWRITE = write_q;
  assign HSIZE  = {1'b0, size_q};
  assign HWDATA = wdata_q;

endmodule
`default_nettype wire
